if_stage: RTL

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the fetch PC and issues requests to instruction memory over a valid/ready request channel with a variable-latency response channel. It drives the IF/ID pipeline register (pc, instr, instr_valid) that decode consumes. It takes the branch/jump redirect (taken flag plus target) produced by decode and honours stall requests from the hazard unit.

---
 rtl/if_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, talks to imem over valid/ready,
// and drives the IF/ID register consumed by decode.
module if_stage #(
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [BUS_WIDTH-1:0]   redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [BUS_WIDTH-1:0]   imem_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  output logic [BUS_WIDTH-1:0]   pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [BUS_WIDTH-1:0]   fetch_pc, fetch_pc_n;
  logic                   drop, drop_n;
  logic [INSTR_WIDTH-1:0] skid, skid_n;
  logic                   load;
  logic [INSTR_WIDTH-1:0] load_instr;

  logic                 eff_redir;
  logic                 hs;
  logic [BUS_WIDTH-1:0] target;
  logic [BUS_WIDTH-1:0] seq_pc;

  assign eff_redir      = redirect & ~stall;
  assign target         = {redirect_pc[BUS_WIDTH-1:2], 2'b00};
  assign seq_pc         = fetch_pc + BUS_WIDTH'(4);
  assign imem_req_valid = (state == REQ);
  assign imem_addr      = fetch_pc;
  assign hs             = imem_req_valid & imem_req_ready;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    drop_n     = drop;
    skid_n     = skid;
    load       = 1'b0;
    load_instr = imem_resp_data;
    unique case (state)
      REQ: begin
        if (hs) begin
          state_n = WAIT;
          if (eff_redir) begin
            drop_n     = 1'b1;
            fetch_pc_n = target;
          end
        end else if (eff_redir) begin
          fetch_pc_n = target;
        end
      end
      WAIT: begin
        if (!imem_resp_valid) begin
          if (eff_redir) begin
            drop_n     = 1'b1;
            fetch_pc_n = target;
          end
        end else if (drop) begin
          // A fresher redirect still wins over the pending target
          drop_n  = 1'b0;
          state_n = REQ;
          if (eff_redir) fetch_pc_n = target;
        end else if (eff_redir) begin
          fetch_pc_n = target;
          state_n    = REQ;
        end else if (!stall) begin
          load       = 1'b1;
          fetch_pc_n = seq_pc;
          state_n    = REQ;
        end else begin
          skid_n  = imem_resp_data;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_n = REQ;
          if (eff_redir) begin
            fetch_pc_n = target;
          end else begin
            load       = 1'b1;
            load_instr = skid;
            fetch_pc_n = seq_pc;
          end
        end
      end
      default: state_n = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      skid     <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      drop     <= drop_n;
      skid     <= skid_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      instr       <= NOP;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        pc          <= fetch_pc;
        instr       <= load_instr;
        instr_valid <= 1'b1;
      end else begin
        instr       <= NOP;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
